// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The host side drives bytes in; the loader side drives ready, the write port and status.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output in_valid, in_byte,
    input  in_ready, we, waddr, wdata, cpu_hold, done, err
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, we, waddr, wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed little-endian byte stream,
// one registered write per assembled word, 8-bit payload checksum, CPU held until done.
module imem_loader #(
  parameter logic [31:0] BASE_PC     = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 512
) (
  input  logic       clk,
  input  logic       rst,
  imem_loader_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  state_t           state, state_nx;
  logic [1:0]       byte_cnt;
  logic [31:0]      shift_q;
  logic [31:0]      len_q;
  logic [IDX_W-1:0] word_idx;
  logic [7:0]       sum_q;
  logic             we_q;
  logic [31:0]      waddr_q, wdata_q;

  logic             fire;
  logic             last_byte;
  logic             word_last;
  logic [31:0]      shift_nx;

  // Length and payload words share one little-endian shift assembler.
  assign fire      = bus.in_valid && bus.in_ready;
  assign last_byte = fire && (byte_cnt == 2'd3);
  assign shift_nx  = {bus.in_byte, shift_q[31:8]};
  assign word_last = ((32'(word_idx) + 32'd1) == len_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LEN: if (last_byte) begin
        if (shift_nx > 32'(DEPTH_WORDS)) state_nx = S_ERR;
        else if (shift_nx == 32'd0)      state_nx = S_CSUM;
        else                             state_nx = S_DATA;
      end
      S_DATA: if (last_byte && word_last) state_nx = S_CSUM;
      S_CSUM: if (fire) state_nx = (bus.in_byte == sum_q) ? S_DONE : S_ERR;
      S_DONE:  state_nx = S_DONE;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_LEN;
    endcase
  end

  always_comb begin
    bus.in_ready = !rst && (state == S_LEN || state == S_DATA || state == S_CSUM);
    bus.cpu_hold = (state != S_DONE);
    bus.done     = (state == S_DONE);
    bus.err      = (state == S_ERR);
    bus.we       = we_q;
    bus.waddr    = waddr_q;
    bus.wdata    = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      shift_q  <= '0;
      len_q    <= '0;
      word_idx <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= BASE_PC;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (fire && (state == S_LEN || state == S_DATA)) begin
        shift_q  <= shift_nx;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (last_byte && state == S_LEN) len_q <= shift_nx;
      if (fire && state == S_DATA) begin
        sum_q <= sum_q + bus.in_byte;
        if (byte_cnt == 2'd3) begin
          we_q     <= 1'b1;
          waddr_q  <= BASE_PC + (32'(word_idx) << 2);
          wdata_q  <= shift_nx;
          word_idx <= word_idx + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes instruction memory, the writer counterpart to the combinational instruction-fetch read port. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one write per word at `BASE_PC`-relative addresses. It verifies an 8-bit checksum and holds the CPU in reset until a complete, valid image is loaded. It sits between the host byte link (UART/debug bridge) and the instruction memory write port.

## Interface
- `BASE_PC`, 32'h0000_0000, byte address of instruction word 0; must match the instruction memory's base.
- `DEPTH_WORDS`, 512, instruction memory capacity in words; the largest accepted image.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a byte is offered on `in_byte`.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  instruction memory write strobe, one cycle per word.
- `waddr`  out  32  byte address of the word being written.
- `wdata`  out  32  word being written.
- `cpu_hold`  out  1  holds the CPU in reset while high.
- `done`  out  1  image loaded and checksum matched; sticky.
- `err`  out  1  oversize image or checksum mismatch; sticky.

## Operation
- Stream format: 4-byte length N (word count, little-endian, full 32 bits), then 4·N payload bytes (each word little-endian, byte 0 = bits [7:0]), then 1 checksum byte.
- Checksum: sum of all 4·N payload bytes, mod 256. Length bytes are excluded.
- A byte transfers on a rising edge where `in_valid && in_ready`. No other cycle changes the byte counters.
- FSM states: LEN, DATA, CSUM, DONE, ERR. `rst` forces LEN.
- LEN:
  - Collect 4 bytes.
  - After the 4th byte: N > DEPTH_WORDS → ERR; N == 0 → CSUM; otherwise → DATA.
- DATA:
  - Shift bytes into a word assembler and add each byte to the running sum.
  - After the 4th byte of word i, issue the write with `waddr = BASE_PC + 4·i` (32-bit wrap) and `wdata` = the assembled word.
  - After word N−1 → CSUM.
- CSUM:
  - One byte; equal to the running sum → DONE, otherwise → ERR.
- DONE and ERR: terminal until `rst`. `in_ready` is 0 and input bytes are ignored.
- `in_ready = !rst && state ∈ {LEN, DATA, CSUM}`. It never deasserts mid-image, because the write port always accepts.
- Word index counter width: clog2(DEPTH_WORDS)+1. Comparison against N uses the full 32-bit length.
- `cpu_hold = !(state == DONE)`. It stays 1 in ERR.
- Writes already issued before an ERR are not undone. `cpu_hold` keeps the CPU from running the partial image.

## Timing
- Reset values (the cycle after `rst` is sampled high): `we`=0, `waddr`=BASE_PC, `wdata`=0, `done`=0, `err`=0, `cpu_hold`=1. `in_ready` is 0 while `rst`=1 and 1 the first cycle after.
- Write latency:
  - `we`, `waddr` and `wdata` are registered.
  - `we` is high for exactly the one cycle after the edge that accepted a word's 4th byte.
  - `waddr` and `wdata` hold their values until the next write.
- Back-to-back bytes give a maximum of one write every 4 cycles. Gaps in `in_valid` just stretch the load; the assembler retains partial bytes indefinitely.
- `done`/`err` rise the cycle after the CSUM byte is accepted. For oversize, `err` rises the cycle after the 4th length byte. `cpu_hold` falls in the same cycle `done` rises.
- Reset mid-operation discards partial length, word and sum state. No `we` issues for a partial word, and the next byte is treated as length byte 0.

## Test plan
- N=1, bytes `01 00 00 00 93 00 50 00 E3`, back-to-back → exactly one `we`, with `waddr`=0x0000_0000 and `wdata`=0x0050_0093 → `done`=1, `cpu_hold`=0 the cycle after `E3`.
- `BASE_PC`=0x8000_0000, N=3 with random `in_valid` gaps, correct checksum → `waddr` = 0x8000_0000, 0x8000_0004, 0x8000_0008 in order, 3 `we` pulses, `done`=1.
- `DEPTH_WORDS`=512, length `01 02 00 00` (N=513) → `err`=1 the cycle after the 4th byte, `in_ready`=0, no `we` ever, `cpu_hold`=1.
- N=0 with checksum 0x00 → `done`=1 with no `we`. N=0 with checksum 0x01 → `err`=1.
- N=2 with a wrong checksum → 2 `we` pulses occur, then `err`=1, `done`=0, `cpu_hold` stays 1. Subsequent `in_valid` bytes are ignored.
- `rst` pulsed after 2 payload bytes of word 0, then a full valid N=1 image → no `we` before the reset. After it, one `we` with `waddr`=BASE_PC, then `done`=1.
